// File: rtl/mips_multicycle_control_if.sv
// Bus between the multi-cycle MIPS controller and its datapath.
// The master side is the controller, which drives strobes, selects and
// debug counters. The slave side is the datapath/IR, which supplies
// opcode, funct, the ALU zero flag and the memory ready.
interface mips_multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;

  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       mem_to_reg;
  logic [1:0]       reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired_count;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal, state, retired_count, cycle_count
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal, state, retired_count, cycle_count
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM with memory wait states, jal/jr,
// illegal-opcode trap and retired/cycle counters.
//
// state   | code | meaning
// FETCH   | 0    | read instruction at PC, PC+4 -> PC when memory ready
// DECODE  | 1    | register read, branch target -> ALUOut
// MEMADR  | 2    | lw/sw effective address
// MEMRD   | 3    | data read at ALUOut, wait for ready
// MEMWB   | 4    | MDR -> rt
// MEMWR   | 5    | data write at ALUOut, wait for ready
// EXEC    | 6    | R-type ALU operation
// ALUWB   | 7    | ALUOut -> rd
// BRANCH  | 8    | beq compare, conditional PC load
// ADDIEX  | 9    | A + imm
// ADDIWB  | 10   | ALUOut -> rt
// JUMP    | 11   | jump target -> PC
// JAL     | 12   | jump target -> PC, PC(+4) -> r31
// JR      | 13   | A -> PC
// TRAP    | 14   | illegal opcode, parked until reset
module mips_multicycle_control #(
  parameter int CNT_W           = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter bit ENABLE_JAL      = 1'b1,
  parameter bit ENABLE_JR       = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  mips_multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
    JAL    = 4'd12, JR     = 4'd13, TRAP   = 4'd14
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_o;
  logic [CNT_W-1:0] retired_q, cycle_q;
  logic             illegal_op;
  logic             retire;

  // Zero is combined with pc_write_cond inside the datapath's PC-load logic.
  logic unused_zero;
  assign unused_zero = bus.zero;

  // Moore output table. FETCH's PCWrite/IRWrite are added later, gated by ready.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'd1; end
      DECODE: c.alu_src_b = 2'd3;
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 2'd1; end
      MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'd2; end
      ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 2'd1; end
      BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'd1;
        c.pc_write_cond = 1'b1; c.pc_source = 2'd1;
      end
      ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      ADDIWB: c.reg_write = 1'b1;
      JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'd2; end
      JAL:    begin
        c.pc_write = 1'b1; c.pc_source = 2'd2;
        c.reg_write = 1'b1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2;
      end
      JR:     begin c.pc_write = 1'b1; c.pc_source = 2'd3; end
      TRAP:   c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Classify the opcode as unsupported for this configuration.
  always_comb begin
    illegal_op = 1'b0;
    case (bus.opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: illegal_op = 1'b0;
      OP_JAL:  illegal_op = !ENABLE_JAL;
      default: illegal_op = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        if (illegal_op) begin
          state_d = TRAP_ON_ILLEGAL ? TRAP : FETCH;
        end else begin
          case (bus.opcode)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_RTYPE:     state_d = (ENABLE_JR && bus.funct == FN_JR) ? JR : EXEC;
            OP_BEQ:       state_d = BRANCH;
            OP_ADDI:      state_d = ADDIEX;
            OP_J:         state_d = JUMP;
            OP_JAL:       state_d = JAL;
            default:      state_d = FETCH;
          endcase
        end
      end
      MEMADR: state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (bus.mem_ready) state_d = MEMWB;
      MEMWR:  if (bus.mem_ready) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, JAL, JR: state_d = FETCH;
      TRAP:   state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Final cycle of an instruction bumps the retired counter.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, JAL, JR: retire = 1'b1;
      MEMWR:   retire = bus.mem_ready;
      DECODE:  retire = illegal_op && !TRAP_ON_ILLEGAL;
      default: retire = 1'b0;
    endcase
  end

  // State, registered control word and counters; the control word is
  // registered alongside the state so selects come straight from flops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= FETCH;
      ctrl_q    <= decode_ctrl(FETCH);
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Fetch handshake gating and reset blanking of everything driven out.
  always_comb begin
    ctrl_o = ctrl_q;
    if (state_q == FETCH) begin
      ctrl_o.pc_write = bus.mem_ready;
      ctrl_o.ir_write = bus.mem_ready;
    end
    if (reset_i) ctrl_o = '0;
  end

  assign bus.pc_write      = ctrl_o.pc_write;
  assign bus.pc_write_cond = ctrl_o.pc_write_cond;
  assign bus.iord          = ctrl_o.iord;
  assign bus.mem_read      = ctrl_o.mem_read;
  assign bus.mem_write     = ctrl_o.mem_write;
  assign bus.ir_write      = ctrl_o.ir_write;
  assign bus.mem_to_reg    = ctrl_o.mem_to_reg;
  assign bus.reg_dst       = ctrl_o.reg_dst;
  assign bus.reg_write     = ctrl_o.reg_write;
  assign bus.alu_src_a     = ctrl_o.alu_src_a;
  assign bus.alu_src_b     = ctrl_o.alu_src_b;
  assign bus.alu_op        = ctrl_o.alu_op;
  assign bus.pc_source     = ctrl_o.pc_source;
  assign bus.illegal       = ctrl_o.illegal;
  assign bus.state         = state_q;
  assign bus.retired_count = retired_q;
  assign bus.cycle_count   = cycle_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: a default-parameter instance
// and a second one with NOP-on-illegal, jal/jr disabled and 4-bit counters.
module tb_mips_multicycle_control;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                 S_MEMWB = 4, S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7,
                 S_BRANCH = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JUMP = 11,
                 S_JAL = 12, S_JR = 13, S_TRAP = 14;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       zero = 1'b0;
  logic       ready = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  int         sel = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         ir_pulses = 0;

  always #5 clk = ~clk;

  mips_multicycle_control_if #(.CNT_W(32)) b1 ();
  mips_multicycle_control_if #(.CNT_W(4))  b2 ();

  assign b1.opcode = opcode;  assign b2.opcode = opcode;
  assign b1.funct  = funct;   assign b2.funct  = funct;
  assign b1.zero   = zero;    assign b2.zero   = zero;
  assign b1.mem_ready = ready; assign b2.mem_ready = ready;

  mips_multicycle_control #(.CNT_W(32)) dut1 (
    .clk_i(clk), .reset_i(reset), .bus(b1.master));
  mips_multicycle_control #(.CNT_W(4), .TRAP_ON_ILLEGAL(1'b0),
                            .ENABLE_JAL(1'b0), .ENABLE_JR(1'b0)) dut2 (
    .clk_i(clk), .reset_i(reset), .bus(b2.master));

  // {pcw, pcwc, iord, mrd, mwr, irw, m2r[1:0], rdst[1:0], rw, asa,
  //  asb[1:0], aop[1:0], psrc[1:0], ill}
  logic [18:0] obs1, obs2, obs;
  logic [3:0]  obs_state;
  logic [31:0] obs_ret, obs_cyc;

  assign obs1 = {b1.pc_write, b1.pc_write_cond, b1.iord, b1.mem_read, b1.mem_write,
                 b1.ir_write, b1.mem_to_reg, b1.reg_dst, b1.reg_write, b1.alu_src_a,
                 b1.alu_src_b, b1.alu_op, b1.pc_source, b1.illegal};
  assign obs2 = {b2.pc_write, b2.pc_write_cond, b2.iord, b2.mem_read, b2.mem_write,
                 b2.ir_write, b2.mem_to_reg, b2.reg_dst, b2.reg_write, b2.alu_src_a,
                 b2.alu_src_b, b2.alu_op, b2.pc_source, b2.illegal};

  always_comb begin
    if (sel == 0) begin
      obs = obs1; obs_state = b1.state;
      obs_ret = b1.retired_count; obs_cyc = b1.cycle_count;
    end else begin
      obs = obs2; obs_state = b2.state;
      obs_ret = {28'd0, b2.retired_count}; obs_cyc = {28'd0, b2.cycle_count};
    end
  end

  // Expected control word for a state, straight from the output table.
  function automatic logic [18:0] exp_ctrl(input int st, input logic rdy);
    logic pcw, pcwc, iord, mrd, mwr, irw, rw, asa, ill;
    logic [1:0] m2r, rdst, asb, aop, ps;
    {pcw, pcwc, iord, mrd, mwr, irw, rw, asa, ill} = '0;
    {m2r, rdst, asb, aop, ps} = '0;
    case (st)
      S_FETCH:  begin mrd = 1; asb = 2'd1; pcw = rdy; irw = rdy; end
      S_DECODE: asb = 2'd3;
      S_MEMADR: begin asa = 1; asb = 2'd2; end
      S_MEMRD:  begin mrd = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 2'd1; end
      S_MEMWR:  begin mwr = 1; iord = 1; end
      S_EXEC:   begin asa = 1; aop = 2'd2; end
      S_ALUWB:  begin rw = 1; rdst = 2'd1; end
      S_BRANCH: begin asa = 1; aop = 2'd1; pcwc = 1; ps = 2'd1; end
      S_ADDIEX: begin asa = 1; asb = 2'd2; end
      S_ADDIWB: rw = 1;
      S_JUMP:   begin pcw = 1; ps = 2'd2; end
      S_JAL:    begin pcw = 1; ps = 2'd2; rw = 1; rdst = 2'd2; m2r = 2'd2; end
      S_JR:     begin pcw = 1; ps = 2'd3; end
      S_TRAP:   ill = 1;
      default:  ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, ps, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive ready, check state/outputs, then advance.
  task automatic step(input logic rdy, input int st);
    ready = rdy;
    #1;
    check("state", {28'd0, obs_state}, st);
    check("ctrl", {13'd0, obs}, {13'd0, exp_ctrl(st, rdy)});
    check("rd_wr_excl", {31'd0, obs[15] & obs[14]}, 32'd0);
    if (obs[13]) ir_pulses++;
    @(posedge clk); #1;
  endtask

  task automatic counters(input string tag, input int ret, input int cyc);
    check({tag, "_retired"}, obs_ret, ret);
    check({tag, "_cycles"}, obs_cyc, cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1; ready = 1'b1;
    #1;
    check("reset_outputs", {13'd0, obs}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_state", {28'd0, obs_state}, S_FETCH);
    counters("reset", 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // R-type add
    sel = 0;
    @(posedge clk); #1;
    do_reset();
    opcode = 6'b000000; funct = 6'b100000;
    step(1, S_FETCH); step(1, S_DECODE); step(1, S_EXEC); step(1, S_ALUWB);
    check("add_state_end", {28'd0, obs_state}, S_FETCH);
    counters("add", 1, 4);

    // lw: 2 wait cycles in FETCH, 3 in MEMRD
    do_reset();
    opcode = 6'b100011; ir_pulses = 0;
    step(0, S_FETCH); step(0, S_FETCH); step(1, S_FETCH);
    step(1, S_DECODE); step(1, S_MEMADR);
    step(0, S_MEMRD); step(0, S_MEMRD); step(0, S_MEMRD); step(1, S_MEMRD);
    step(1, S_MEMWB);
    check("lw_ir_pulses", ir_pulses, 1);
    counters("lw", 1, 10);

    // beq taken, then not taken
    do_reset();
    opcode = 6'b000100; zero = 1'b1;
    step(1, S_FETCH); step(1, S_DECODE); step(1, S_BRANCH);
    zero = 1'b0;
    step(1, S_FETCH); step(1, S_DECODE); step(1, S_BRANCH);
    counters("beq", 2, 6);

    // jal, jr, sw, addi, j
    opcode = 6'b000011;
    step(1, S_FETCH); step(1, S_DECODE); step(1, S_JAL);
    opcode = 6'b000000; funct = 6'b001000;
    step(1, S_FETCH); step(1, S_DECODE); step(1, S_JR);
    counters("jal_jr", 4, 12);
    opcode = 6'b101011;
    step(1, S_FETCH); step(1, S_DECODE); step(1, S_MEMADR); step(1, S_MEMWR);
    opcode = 6'b001000;
    step(1, S_FETCH); step(1, S_DECODE); step(1, S_ADDIEX); step(1, S_ADDIWB);
    opcode = 6'b000010;
    step(1, S_FETCH); step(1, S_DECODE); step(1, S_JUMP);
    counters("sw_addi_j", 7, 23);

    // Illegal opcode traps and holds
    do_reset();
    opcode = 6'b111111;
    step(1, S_FETCH); step(1, S_DECODE);
    for (int i = 0; i < 20; i++) begin
      counters("trap", 0, 2 + i);
      step(1, S_TRAP);
    end
    counters("trap_end", 0, 22);
    do_reset();

    // Reset during the second MEMWR wait cycle
    opcode = 6'b101011;
    step(1, S_FETCH); step(1, S_DECODE); step(1, S_MEMADR); step(0, S_MEMWR);
    reset = 1'b1; ready = 1'b0;
    #1;
    check("abort_state", {28'd0, obs_state}, S_MEMWR);
    check("abort_mem_write", {31'd0, obs[14]}, 32'd0);
    check("abort_outputs", {13'd0, obs}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; ready = 1'b1;
    check("abort_next_state", {28'd0, obs_state}, S_FETCH);
    counters("abort", 0, 0);

    // NOP-on-illegal, jal/jr disabled, 4-bit counters
    sel = 1;
    do_reset();
    opcode = 6'b111111;
    step(1, S_FETCH); step(1, S_DECODE);
    check("nop_state", {28'd0, obs_state}, S_FETCH);
    counters("nop", 1, 2);
    opcode = 6'b000011;
    step(1, S_FETCH); step(1, S_DECODE);
    counters("nojal", 2, 4);
    opcode = 6'b000000; funct = 6'b001000;
    step(1, S_FETCH); step(1, S_DECODE); step(1, S_EXEC); step(1, S_ALUWB);
    counters("nojr", 3, 8);
    opcode = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      step(1, S_FETCH); step(1, S_DECODE); step(1, S_JUMP);
    end
    counters("wrap", 6, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS control path.
- Moore FSM that sequences one instruction over 3–5 cycles through a shared instruction/data memory with a ready handshake.
- Adds jal/jr handling, memory wait states, an illegal-opcode trap, and retired-instruction and cycle counters.
- Sits between the instruction register (opcode/funct inputs) and the multi-cycle datapath (PC, IR, MDR, A/B, ALUOut registers, muxes).

Parameters:
- CNT_W, 32, width of RetiredCount and CycleCount (both wrap modulo 2^CNT_W).
- TRAP_ON_ILLEGAL, 1: 1 = illegal opcode enters TRAP; 0 = illegal opcode retires as a NOP.
- ENABLE_JAL, 1: 0 = opcode 000011 is treated as illegal.
- ENABLE_JR, 1: 0 = R-type funct 001000 executes as an ordinary R-type instruction.

Ports:
- Clk  in  1  clock, all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Opcode  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory has completed the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if Zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR load.
- MemToReg  out  2  write-back source: 0 = ALUOut, 1 = MDR, 2 = PC.
- RegDst  out  2  destination register: 0 = rt, 1 = rd, 2 = r31.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B operand: 0 = B, 1 = 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- ALUOp  out  2  to the ALU control decoder: 0 = add, 1 = sub, 2 = funct.
- PCSource  out  2  next-PC source: 0 = ALU, 1 = ALUOut, 2 = jump target, 3 = A (jr).
- Illegal  out  1  high while in TRAP.
- State  out  4  current state encoding, for debug.
- RetiredCount  out  CNT_W  instructions completed.
- CycleCount  out  CNT_W  cycles since reset.

Behaviour:
- Reset (synchronous, active-high): State = FETCH; both counters = 0. While Reset is high, every strobe (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) is forced 0; all select outputs are 0.
- Outputs are a pure function of State, except in FETCH, where PCWrite and IRWrite are gated by MemReady.
- Unless stated otherwise, each state lasts one cycle and moves to the next state on the following edge.
- States and their outputs:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0, IRWrite=PCWrite=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target precomputed into ALUOut). Next state by opcode:
    - lw/sw (100011/101011) -> MEMADR
    - R-type (000000) -> JR if ENABLE_JR and Funct=001000, otherwise EXEC
    - beq (000100) -> BRANCH
    - addi (001000) -> ADDIEX
    - j (000010) -> JUMP
    - jal (000011, ENABLE_JAL) -> JAL
    - anything else -> TRAP if TRAP_ON_ILLEGAL, otherwise FETCH (retires as a NOP)
  - MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD: MemRead=1, IorD=1. Holds until MemReady, then goes to MEMWB.
  - MEMWB: RegWrite=1, RegDst=0, MemToReg=1. Goes to FETCH.
  - MEMWR: MemWrite=1, IorD=1. Holds until MemReady, then goes to FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Goes to ALUWB.
  - ALUWB: RegWrite=1, RegDst=1, MemToReg=0. Goes to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. Goes to FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Goes to ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0, MemToReg=0. Goes to FETCH.
  - JUMP: PCWrite=1, PCSource=2. Goes to FETCH.
  - JAL: PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemToReg=2 (PC already holds PC+4). Goes to FETCH.
  - JR: PCWrite=1, PCSource=3. Goes to FETCH.
  - TRAP: Illegal=1, all strobes 0. Stays in TRAP until Reset.
- Latency with MemReady tied high: beq/j/jal/jr = 3 cycles; R-type/addi/sw = 4 cycles; lw = 5 cycles. Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- MemRead and MemWrite are never high in the same cycle.
- RetiredCount increments by 1 on the final cycle of each instruction:
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, JAL, JR;
  - MEMWR when MemReady=1;
  - DECODE of an illegal opcode when TRAP_ON_ILLEGAL=0.
  - It does not increment in TRAP.
- CycleCount increments every non-Reset cycle, including TRAP. Both counters wrap at 2^CNT_W.
- Reset asserted mid-instruction (any state, including a wait state): the next state is FETCH and no strobe is asserted in the Reset cycle; any partial memory access is abandoned.

Test Plan:
- Reset, MemReady=1, then R-type add (Opcode 0, Funct 100000) -> states FETCH, DECODE, EXEC, ALUWB; RegWrite=1 with RegDst=1 only in ALUWB; RetiredCount=1 after 4 cycles.
- lw with MemReady low for 2 cycles in FETCH and 3 cycles in MEMRD -> 10 cycles in total; IRWrite pulses exactly once; RegWrite with MemToReg=1 in the last cycle; CycleCount=10.
- beq with Zero=1, then beq with Zero=0 -> PCWriteCond=1 and PCSource=1 in the BRANCH cycle of both; each instruction takes 3 cycles; RetiredCount=2.
- jal, then jr (Funct 001000) -> JAL asserts RegDst=2, MemToReg=2, PCWrite=1, PCSource=2; JR asserts PCSource=3; no RegWrite in JR.
- Opcode 111111 with TRAP_ON_ILLEGAL=1 -> Illegal=1 held for 20 cycles; RetiredCount frozen; CycleCount still advancing; Reset returns State to FETCH with both counters 0. With TRAP_ON_ILLEGAL=0 the same opcode retires in 2 cycles.
- Reset asserted during the 2nd MEMWR wait cycle -> MemWrite=0 in that cycle; next State = FETCH; counters = 0.
